// File: rtl/timer_digit_display.sv
// Two-digit multiplexed common-anode seven-segment driver for the BCD countdown timer.
// Alternates ones/tens slots with a blanking guard at each switch, snapshots the inputs once per
// frame so a frame never tears, blanks a leading tens zero and blinks the display after time-out.
// All outputs are registered.
module timer_digit_display #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned GUARD       = 4,
  parameter int unsigned BLINK_SLOTS = 250,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       DigitTime_out,
  input  logic [3:0] DigitCount1,
  input  logic [3:0] DigitCount2,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_start
);

  localparam int unsigned CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  localparam logic [CntW-1:0]   SlotLast  = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]   GuardEnd  = CntW'(GUARD);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_SLOTS - 1);

  localparam logic [6:0] SegDark = 7'h7F;
  localparam logic [1:0] AnOff   = 2'b11;
  localparam logic [1:0] AnOnes  = 2'b10;
  localparam logic [1:0] AnTens  = 2'b01;

  typedef enum logic [1:0] {StIdle, StOnes, StTens} state_e;

  state_e            state_q;
  logic [CntW-1:0]   slot_cnt_q;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_on_q;
  logic [3:0]        ones_q;
  logic [3:0]        tens_q;
  logic              timeout_q;

  logic       slot_end;
  logic       enter_ones;
  logic       tens_lz;
  logic [6:0] seg_d;
  logic [1:0] an_d;

  // Active-low gfedcba pattern; invalid BCD shows a lone middle bar.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign slot_end   = (state_q != StIdle) && (slot_cnt_q == SlotLast);
  // A new frame begins leaving IDLE or at the end of the tens slot; this is the snapshot point.
  assign enter_ones = enable && ((state_q == StIdle) || ((state_q == StTens) && slot_end));
  assign tens_lz    = LZ_BLANK && (tens_q == 4'd0) && !timeout_q;

  // Next display value from the current slot position; registered below (one-cycle latency).
  always_comb begin
    seg_d = SegDark;
    an_d  = AnOff;
    if (blink_on_q && (slot_cnt_q >= GuardEnd)) begin
      case (state_q)
        StOnes: begin
          seg_d = bcd_to_seg(ones_q);
          an_d  = AnOnes;
        end
        StTens: begin
          if (!tens_lz) begin
            seg_d = bcd_to_seg(tens_q);
            an_d  = AnTens;
          end
        end
        default: ;
      endcase
    end
  end

  // Scan FSM, slot/blink counters, frame snapshots and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      slot_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      timeout_q   <= 1'b0;
      seg         <= SegDark;
      an          <= AnOff;
      frame_start <= 1'b0;
    end else if (!enable) begin
      state_q     <= StIdle;
      slot_cnt_q  <= '0;
      seg         <= SegDark;
      an          <= AnOff;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_d;
      an          <= an_d;
      frame_start <= enter_ones;

      case (state_q)
        StIdle: begin
          state_q    <= StOnes;
          slot_cnt_q <= '0;
        end
        StOnes: begin
          if (slot_end) begin
            state_q    <= StTens;
            slot_cnt_q <= '0;
          end else begin
            slot_cnt_q <= slot_cnt_q + 1'b1;
          end
        end
        StTens: begin
          if (slot_end) begin
            state_q    <= StOnes;
            slot_cnt_q <= '0;
          end else begin
            slot_cnt_q <= slot_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          slot_cnt_q <= '0;
        end
      endcase

      if (enter_ones) begin
        ones_q    <= DigitCount1;
        tens_q    <= DigitCount2;
        timeout_q <= DigitTime_out;
      end

      // A falling time-out clears blink at the snapshot; a rising one starts from the lit phase.
      if ((enter_ones && !DigitTime_out) || !timeout_q) begin
        blink_cnt_q <= '0;
        blink_on_q  <= 1'b1;
      end else if (slot_end) begin
        if (blink_cnt_q == BlinkLast) begin
          blink_cnt_q <= '0;
          blink_on_q  <= !blink_on_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_digit_display.sv
// Bench for timer_digit_display with SCAN_DIV=8, GUARD=2, BLINK_SLOTS=2, LZ_BLANK=1.
// A vector table chains frames (new inputs driven mid-frame, checked one frame later); hand-written
// sequences cover blink, reset during blink-off and enable toggling. Expected outputs go through
// a scoreboard queue one cycle ahead of the registered DUT outputs.
module tb_timer_digit_display;

  localparam int SD = 8;
  localparam int GD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       to_in;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] d1;
    logic [3:0] d2;
    logic       to;
    logic [6:0] s1;
    logic [6:0] s2;
    logic [1:0] a2;
  } vec_t;

  typedef struct packed {
    logic       fs;
    logic [1:0] an;
    logic [6:0] seg;
  } obs_t;

  vec_t vecs[8];
  obs_t sb[$];

  timer_digit_display #(
    .SCAN_DIV   (SD),
    .GUARD      (GD),
    .BLINK_SLOTS(2),
    .LZ_BLANK   (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .DigitTime_out(to_in),
    .DigitCount1  (d1),
    .DigitCount2  (d2),
    .seg          (seg),
    .an           (an),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic t);
    d1    = a;
    d2    = b;
    to_in = t;
  endtask

  task automatic chk_dark(input string name);
    chk({name, " an"}, {30'd0, an}, 32'h3);
    chk({name, " seg"}, {25'd0, seg}, 32'h7F);
  endtask

  // Wait (bounded) for a frame_start pulse, sampled at the falling edge.
  task automatic wait_frame();
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (frame_start) seen = 1'b1;
    end
    chk("frame_start timeout", {31'd0, seen}, 32'd1);
  endtask

  // Called at the falling edge of a frame_start cycle; checks the 16 output cycles of that frame
  // and ends on the falling edge of the next frame_start.
  task automatic check_frame(input logic [6:0] s1, input logic [1:0] a1,
                             input logic [6:0] s2, input logic [1:0] a2);
    obs_t e;
    int   cnt;
    for (int j = 0; j < 2 * SD; j++) begin
      cnt  = j % SD;
      e.fs = (j == 2 * SD - 1);
      if (cnt < GD) begin
        e.an  = 2'b11;
        e.seg = 7'h7F;
      end else if (j < SD) begin
        e.an  = a1;
        e.seg = s1;
      end else begin
        e.an  = a2;
        e.seg = s2;
      end
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("slot%0d an", j), {30'd0, an}, {30'd0, e.an});
      chk($sformatf("slot%0d seg", j), {25'd0, seg}, {25'd0, e.seg});
      chk($sformatf("slot%0d frame_start", j), {31'd0, frame_start}, {31'd0, e.fs});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd3, 4'd5, 1'b0, 7'h30, 7'h12, 2'b01};
    vecs[1] = '{4'd7, 4'd5, 1'b0, 7'h78, 7'h12, 2'b01};
    vecs[2] = '{4'd4, 4'd0, 1'b0, 7'h19, 7'h7F, 2'b11};
    vecs[3] = '{4'd0, 4'd0, 1'b1, 7'h40, 7'h40, 2'b01};
    vecs[4] = '{4'd8, 4'hC, 1'b0, 7'h00, 7'h3F, 2'b01};
    vecs[5] = '{4'd9, 4'd1, 1'b0, 7'h10, 7'h79, 2'b01};
    vecs[6] = '{4'd2, 4'd6, 1'b0, 7'h24, 7'h02, 2'b01};
    vecs[7] = '{4'd0, 4'd0, 1'b0, 7'h40, 7'h7F, 2'b11};

    rst    = 1'b1;
    enable = 1'b1;
    set_in(vecs[0].d1, vecs[0].d2, vecs[0].to);
    repeat (3) @(negedge clk);
    chk_dark("reset");
    chk("reset frame_start", {31'd0, frame_start}, 32'd0);
    rst = 1'b0;
    wait_frame();

    // Each new vector is driven mid-ONES slot and must only appear one frame later.
    for (int i = 1; i < 8; i++) begin
      set_in(vecs[i].d1, vecs[i].d2, vecs[i].to);
      check_frame(vecs[i-1].s1, 2'b10, vecs[i-1].s2, vecs[i-1].a2);
    end

    // Time-out on "00": two lit slots, two dark slots, tens zero not blanked.
    set_in(4'd0, 4'd0, 1'b1);
    check_frame(vecs[7].s1, 2'b10, vecs[7].s2, vecs[7].a2);
    check_frame(7'h40, 2'b10, 7'h40, 2'b01);
    check_frame(7'h7F, 2'b11, 7'h7F, 2'b11);
    check_frame(7'h40, 2'b10, 7'h40, 2'b01);

    // Reset in the middle of the dark phase; blink restarts lit afterwards.
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_dark("rst blink-off");
    chk("rst blink-off frame_start", {31'd0, frame_start}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_frame();
    set_in(4'd3, 4'd5, 1'b0);
    check_frame(7'h40, 2'b10, 7'h40, 2'b01);

    // Disable mid-TENS, then re-enable for a fresh frame.
    repeat (10) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk_dark("disable");
    repeat (3) begin
      @(negedge clk);
      chk_dark("idle");
      chk("idle frame_start", {31'd0, frame_start}, 32'd0);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("reenable frame_start", {31'd0, frame_start}, 32'd1);
    check_frame(7'h30, 2'b10, 7'h12, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
